fetch_sequencer: RTL and testbench

//  Multi-cycle Y86-64 fetch controller. Reads instruction bytes one at a time from a

---
 rtl/fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch controller: reads one instruction byte per memory response,
// assembles icode/ifun, rA/rB, valC and valP, then presents the instruction to decode.
module fetch_sequencer #(
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_err,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [3:0]    icode,
  output logic [3:0]    ifun,
  output logic [3:0]    rA,
  output logic [3:0]    rB,
  output logic [63:0]   valC,
  output logic [AW-1:0] valP,
  output logic [1:0]    stat,
  output logic          busy
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BYTE0   = 3'd1,
    REGS    = 3'd2,
    VALC    = 3'd3,
    PRESENT = 3'd4,
    HALTED  = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] pc;
  logic [2:0]    k;
  logic          need_regids, need_valc;
  logic [3:0]    off;
  logic [3:0]    byte_icode;
  logic          last_byte;

  function automatic logic regids_f(input logic [3:0] ic);
    return ic inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11};
  endfunction

  function automatic logic valc_f(input logic [3:0] ic);
    return ic inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // last_byte marks the response that ends fetching: normal completion or an error
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    off        = 4'd0;
    last_byte  = 1'b0;
    byte_icode = mem_rdata[7:4];
    case (state)
      IDLE, HALTED: if (start) state_next = BYTE0;
      BYTE0: begin
        mem_req = 1'b1;
        if (mem_rvalid) begin
          if (mem_err || byte_icode == 4'd0 || byte_icode > 4'd11) last_byte = 1'b1;
          else if (regids_f(byte_icode))                           state_next = REGS;
          else if (valc_f(byte_icode))                             state_next = VALC;
          else                                                     last_byte = 1'b1;
        end
      end
      REGS: begin
        mem_req = 1'b1;
        off     = 4'd1;
        if (mem_rvalid) begin
          if (mem_err || !need_valc) last_byte = 1'b1;
          else                       state_next = VALC;
        end
      end
      VALC: begin
        mem_req = 1'b1;
        off     = 4'd1 + {3'b000, need_regids} + {1'b0, k};
        if (mem_rvalid && (mem_err || k == 3'd7)) last_byte = 1'b1;
      end
      PRESENT: if (out_ready) state_next = (stat != STAT_AOK) ? HALTED : BYTE0;
      default: state_next = IDLE;
    endcase
    if (last_byte) state_next = PRESENT;
    mem_addr = mem_req ? pc + AW'(off) : '0;
  end

  assign out_valid = (state == PRESENT);
  assign busy      = (state != IDLE) && (state != HALTED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      k           <= 3'd0;
      need_regids <= 1'b0;
      need_valc   <= 1'b0;
      icode       <= 4'd0;
      ifun        <= 4'd0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= 64'd0;
      valP        <= '0;
      stat        <= STAT_AOK;
    end else begin
      case (state)
        IDLE, HALTED: if (start) begin
          pc   <= start_pc;
          k    <= 3'd0;
          rA   <= 4'hF;
          rB   <= 4'hF;
          valC <= 64'd0;
          stat <= STAT_AOK;
        end
        BYTE0: if (mem_rvalid && !mem_err) begin
          icode       <= mem_rdata[7:4];
          ifun        <= mem_rdata[3:0];
          need_regids <= regids_f(byte_icode);
          need_valc   <= valc_f(byte_icode);
          if (byte_icode == 4'd0)      stat <= STAT_HLT;
          else if (byte_icode > 4'd11) stat <= STAT_INS;
        end
        REGS: if (mem_rvalid && !mem_err) begin
          rA <= mem_rdata[7:4];
          rB <= mem_rdata[3:0];
        end
        VALC: if (mem_rvalid && !mem_err) begin
          valC[{k, 3'b000} +: 8] <= mem_rdata;
          k                      <= k + 3'd1;
        end
        PRESENT: if (out_ready && stat == STAT_AOK) begin
          pc   <= redirect ? redirect_pc : valP;
          k    <= 3'd0;
          rA   <= 4'hF;
          rB   <= 4'hF;
          valC <= 64'd0;
        end
        default: ;
      endcase
      // The final byte (or the failing one) sits at offset length-1, so valP is its address + 1
      if (last_byte) valP <= mem_addr + AW'(1);
      if (mem_req && mem_rvalid && mem_err) begin
        stat  <= STAT_ADR;
        icode <= 4'd0;
        ifun  <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed programs in a byte memory model,
// expected instructions queued by the stimulus and checked by a handshake monitor.
module tb_fetch_sequencer;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [7:0]    mem_rdata;
  logic          mem_err;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [3:0]    icode, ifun, rA, rB;
  logic [63:0]   valC;
  logic [AW-1:0] valP;
  logic [1:0]    stat;
  logic          busy;

  always #5 clk = ~clk;

  fetch_sequencer #(.AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .out_valid(out_valid),
    .out_ready(out_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .stat(stat), .busy(busy)
  );

  // Byte memory answering one cycle after it sees a request
  logic [7:0]    mem [0:4095];
  logic [AW-1:0] err_addr = '1;
  always @(posedge clk) begin
    if (mem_req && !mem_rvalid) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= mem[mem_addr[11:0]];
      mem_err    <= (mem_addr == err_addr);
    end else begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 8'h00;
      mem_err    <= 1'b0;
    end
  end

  typedef struct packed {
    logic [3:0]    icode;
    logic [3:0]    ifun;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [63:0]   valc;
    logic [AW-1:0] valp;
    logic [1:0]    stat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else             passed++;
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_instr: got icode=%h valP=%h, expected nothing (t=%0t)", icode, valP, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("icode", 64'(icode), 64'(mon_e.icode));
        chk("ifun",  64'(ifun),  64'(mon_e.ifun));
        chk("rA",    64'(rA),    64'(mon_e.ra));
        chk("rB",    64'(rB),    64'(mon_e.rb));
        chk("valC",  valC,       mon_e.valc);
        chk("valP",  valP,       mon_e.valp);
        chk("stat",  64'(stat),  64'(mon_e.stat));
      end
    end
  end

  task automatic push(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, input logic [AW-1:0] vp,
                      input logic [1:0] st);
    exp_t e;
    e = '{icode: ic, ifun: fn, ra: ra, rb: rb, valc: vc, valp: vp, stat: st};
    sb.push_back(e);
  endtask

  task automatic pulse_start(input logic [AW-1:0] pc);
    @(posedge clk); #1;
    start = 1'b1;
    start_pc = pc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin @(posedge clk); #1; n++; end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
    chk(name, 64'(out_valid), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    // irmovq $0x0102030405060708, %rdx at 0x100, halt after
    mem[12'h100] = 8'h30; mem[12'h101] = 8'hF2;
    for (int i = 0; i < 8; i++) mem[12'h102 + i] = 8'(8 - i);
    // addq %rcx, %rdx at 0x200, halt after
    mem[12'h200] = 8'h60; mem[12'h201] = 8'h12;
    // invalid opcode at 0x300; jmp at 0x310 whose 4th byte faults
    mem[12'h300] = 8'hC0;
    mem[12'h310] = 8'h70;
    // jmp 0x40 at 0x400; nop, halt at 0x40
    mem[12'h400] = 8'h70; mem[12'h401] = 8'h40;
    mem[12'h040] = 8'h10;
    // irmovq at 0x500 for the reset test
    mem[12'h500] = 8'h30; mem[12'h501] = 8'hF2;
    for (int i = 0; i < 8; i++) mem[12'h502 + i] = 8'hA0 + 8'(i);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mem_req",   64'(mem_req),   64'd0);
    chk("rst_mem_addr",  mem_addr,       64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_rA",        64'(rA),        64'hF);
    chk("rst_valP",      valP,           64'd0);

    // irmovq then halt
    push(4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708, 64'h10A, 2'd0);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h10B, 2'd1);
    pulse_start(64'h100);
    chk("first_addr", mem_addr, 64'h100);
    wait_idle("t1_halt_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("halted_no_req", 64'(mem_req), 64'd0);
    chk("halted_stat",   64'(stat),    64'd1);

    // decode stall: output held while out_ready is low
    out_ready = 1'b0;
    push(4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'h202, 2'd0);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h203, 2'd1);
    pulse_start(64'h200);
    wait_valid("t2_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid",  64'(out_valid), 64'd1);
      chk("stall_no_req", 64'(mem_req),   64'd0);
      chk("stall_valP",   valP,           64'h202);
      chk("stall_rB",     64'(rB),        64'h2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_next_req",  64'(mem_req), 64'd1);
    chk("t2_next_addr", mem_addr,     64'h202);
    wait_idle("t2_halt_timeout");

    // invalid instruction, then address error on a jmp's 4th byte
    push(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h301, 2'd3);
    pulse_start(64'h300);
    wait_idle("t4_ins_timeout");
    err_addr = 64'h313;
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h314, 2'd2);
    pulse_start(64'h310);
    wait_idle("t4_adr_timeout");
    err_addr = '1;

    // jmp taken via redirect, then nop and halt at the target
    push(4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h409, 2'd0);
    push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 2'd0);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h42, 2'd1);
    pulse_start(64'h400);
    wait_valid("t5_valid_timeout");
    redirect = 1'b1;
    redirect_pc = 64'h40;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("redir_req",  64'(mem_req), 64'd1);
    chk("redir_addr", mem_addr,     64'h40);
    wait_idle("t5_halt_timeout");

    // asynchronous reset in the middle of valC with a response in flight
    pulse_start(64'h500);
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 64'h503) && n < 100) begin @(posedge clk); #1; n++; end
      chk("t6_reach_valc", mem_addr, 64'h503);
    end
    @(posedge clk); #1;
    chk("t6_pending", 64'(mem_rvalid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy",  64'(busy),  64'd0);
    chk("t6_rst_req",   64'(mem_req), 64'd0);
    chk("t6_rst_icode", 64'(icode), 64'd0);
    chk("t6_rst_rB",    64'(rB),    64'hF);
    chk("t6_rst_valC",  valC,       64'd0);
    chk("t6_rst_stat",  64'(stat),  64'd0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_late_busy", 64'(busy),    64'd0);
    chk("t6_late_req",  64'(mem_req), 64'd0);
    chk("t6_late_valC", valC,         64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
